// File: rtl/pipe_io_port.sv
// pipe_io_port: memory-mapped I/O port for the MEM/WB pipeline.
// Three 8-bit output latches (OUT0..OUT2) are converted to two-digit BCD by a
// shared double-dabble engine and shown on six active-low seven-segment digits.
// Two 5-bit input ports return the synchronized, debounced board switches.
// Optional feature macro: IO_HEX_BLANK_EN (blank the tens digit for values < 10).
module pipe_io_port #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [9:0]  sw,
  output logic        io_sel,
  output logic [31:0] rdata,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRBK  = 2'd2
  } state_t;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
`ifdef IO_HEX_BLANK_EN
  localparam logic [6:0] TENS_RST = SEG_BLANK;
`else
  localparam logic [6:0] TENS_RST = SEG_ZERO;
`endif

  // BCD digit to active-low segment code (g..a); anything above 9 shows blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Tens digit code; with blanking enabled a leading zero is suppressed.
  function automatic logic [6:0] tens_seg(input logic [3:0] d);
    logic [6:0] code;
`ifdef IO_HEX_BLANK_EN
    if (d == 4'd0) code = SEG_BLANK;
    else           code = seg7(d);
`else
    code = seg7(d);
`endif
    return code;
  endfunction

  // One double-dabble iteration on {hundreds, tens, ones, binary}.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8]  + 4'd3;
    else                  t[11:8]  = t[11:8];
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    else                  t[15:12] = t[15:12];
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    else                  t[19:16] = t[19:16];
    return {t[18:0], 1'b0};
  endfunction

  state_t          state_r;
  logic [2:0]      pending_r;
  logic [7:0]      out_r [3];
  logic [19:0]     shift_r;
  logic [2:0]      iter_r;
  logic [1:0]      sel_r;
  logic [6:0]      seg_r [6];
  logic            busy_r;

  logic [2:0]      wr_set_s;
  logic [2:0]      clr_s;
  logic [1:0]      pick_s;
  logic [7:0]      snap_s;

  logic [9:0]      sync_a_r;
  logic [9:0]      sync_b_r;
  logic [CW-1:0]   db_cnt_r;
  logic [9:0]      deb_r;

  // Address decode: I/O select, combinational read mux and write strobes.
  always_comb begin
    io_sel   = 1'b0;
    rdata    = 32'd0;
    wr_set_s = 3'b000;
    case (addr[7:0])
      8'h80: begin
        io_sel   = 1'b1;
        rdata    = {24'd0, out_r[0]};
        wr_set_s = {2'b00, we};
      end
      8'h84: begin
        io_sel   = 1'b1;
        rdata    = {24'd0, out_r[1]};
        wr_set_s = {1'b0, we, 1'b0};
      end
      8'h88: begin
        io_sel   = 1'b1;
        rdata    = {24'd0, out_r[2]};
        wr_set_s = {we, 2'b00};
      end
      8'hC0: begin
        io_sel   = 1'b1;
        rdata    = {27'd0, deb_r[4:0]};
      end
      8'hC4: begin
        io_sel   = 1'b1;
        rdata    = {27'd0, deb_r[9:5]};
      end
      default: begin
        io_sel   = 1'b0;
        rdata    = 32'd0;
        wr_set_s = 3'b000;
      end
    endcase
  end

  // Lowest-numbered pending port, its current latch value and the clear strobe.
  always_comb begin
    pick_s = 2'd0;
    snap_s = 8'd0;
    clr_s  = 3'b000;
    if (pending_r[0]) begin
      pick_s = 2'd0;
      snap_s = out_r[0];
    end else if (pending_r[1]) begin
      pick_s = 2'd1;
      snap_s = out_r[1];
    end else if (pending_r[2]) begin
      pick_s = 2'd2;
      snap_s = out_r[2];
    end else begin
      pick_s = 2'd0;
      snap_s = 8'd0;
    end
    if ((state_r == ST_IDLE) && (|pending_r)) clr_s = 3'b001 << pick_s;
    else                                      clr_s = 3'b000;
  end

  // Output latches, pending flags and the BCD converter FSM with segment writeback.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      pending_r <= 3'b000;
      shift_r   <= 20'd0;
      iter_r    <= 3'd0;
      sel_r     <= 2'd0;
      busy_r    <= 1'b0;
      for (int i = 0; i < 3; i++) out_r[i] <= 8'd0;
      for (int i = 0; i < 3; i++) begin
        seg_r[2*i]   <= SEG_ZERO;
        seg_r[2*i+1] <= TENS_RST;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr_set_s[i]) out_r[i] <= wdata[7:0];
        else             out_r[i] <= out_r[i];
      end
      // A write on the same edge as selection keeps the flag set.
      pending_r <= (pending_r & ~clr_s) | wr_set_s;
      case (state_r)
        ST_IDLE: begin
          if (|pending_r) begin
            sel_r   <= pick_s;
            shift_r <= {12'd0, snap_s};
            iter_r  <= 3'd0;
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          shift_r <= dabble_step(shift_r);
          iter_r  <= iter_r + 3'd1;
          busy_r  <= 1'b1;
          if (iter_r == 3'd7) state_r <= ST_WRBK;
          else                state_r <= ST_SHIFT;
        end
        ST_WRBK: begin
          // Hundreds digit is dropped: only value mod 100 is displayed.
          case (sel_r)
            2'd0: begin
              seg_r[0] <= seg7(shift_r[11:8]);
              seg_r[1] <= tens_seg(shift_r[15:12]);
            end
            2'd1: begin
              seg_r[2] <= seg7(shift_r[11:8]);
              seg_r[3] <= tens_seg(shift_r[15:12]);
            end
            2'd2: begin
              seg_r[4] <= seg7(shift_r[11:8]);
              seg_r[5] <= tens_seg(shift_r[15:12]);
            end
            default: begin
            end
          endcase
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Switch path: two-flop synchronizer, stability counter and debounced register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_a_r <= 10'd0;
      sync_b_r <= 10'd0;
      db_cnt_r <= '0;
      deb_r    <= 10'd0;
    end else begin
      sync_a_r <= sw;
      sync_b_r <= sync_a_r;
      if (sync_a_r != sync_b_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_r    <= sync_b_r;
      end else begin
        db_cnt_r <= db_cnt_r + CW'(1);
      end
    end
  end

  assign hex0 = seg_r[0];
  assign hex1 = seg_r[1];
  assign hex2 = seg_r[2];
  assign hex3 = seg_r[3];
  assign hex4 = seg_r[4];
  assign hex5 = seg_r[5];
  assign busy = busy_r;

endmodule

// File: tb/tb_pipe_io_port.sv
// Directed self-checking bench for pipe_io_port (default DEBOUNCE_CYCLES = 16).
// Honours IO_HEX_BLANK_EN when expecting tens-digit codes.
module tb_pipe_io_port;

  logic        clock;
  logic        resetn;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [9:0]  sw;
  logic        io_sel;
  logic [31:0] rdata;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef IO_HEX_BLANK_EN
  localparam logic [6:0] TENS_RST  = 7'h7F;
  localparam logic [6:0] TENS_ZERO = 7'h7F;
`else
  localparam logic [6:0] TENS_RST  = 7'h40;
  localparam logic [6:0] TENS_ZERO = 7'h40;
`endif

  pipe_io_port #(.DEBOUNCE_CYCLES(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .sw     (sw),
    .io_sel (io_sel),
    .rdata  (rdata),
    .hex0   (hex0),
    .hex1   (hex1),
    .hex2   (hex2),
    .hex3   (hex3),
    .hex4   (hex4),
    .hex5   (hex5),
    .busy   (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one write for the next posedge, returns at the following negedge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clock);
    @(negedge clock);
    we    = 1'b0;
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    adv(3);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    we     = 1'b0;
    addr   = 32'h0000_0080;
    wdata  = 32'd0;
    sw     = 10'd0;
    @(negedge clock);
    do_reset();

    // Reset state
    check("rst_hex0", {25'd0, hex0}, 32'h40);
    check("rst_hex1", {25'd0, hex1}, {25'd0, TENS_RST});
    check("rst_hex5", {25'd0, hex5}, {25'd0, TENS_RST});
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out0", rdata, 32'd0);

    // OUT0 = 42: busy after W+1..W+9, digits at W+10
    do_write(32'h0000_0080, 32'h0000_002A);
    check("w42_busy_w0", {31'd0, busy}, 32'd0);
    check("w42_rd", rdata, 32'h2A);
    adv(1);
    check("w42_busy_w1", {31'd0, busy}, 32'd1);
    adv(8);
    check("w42_busy_w9", {31'd0, busy}, 32'd1);
    check("w42_hex0_w9", {25'd0, hex0}, 32'h40);
    adv(1);
    check("w42_busy_w10", {31'd0, busy}, 32'd0);
    check("w42_hex1", {25'd0, hex1}, 32'h19);
    check("w42_hex0", {25'd0, hex0}, 32'h24);

    // OUT2 then OUT1 queued during an OUT0 conversion: OUT1 serviced first
    do_write(32'h0000_0080, 32'h0000_002A);
    adv(1);
    do_write(32'h0000_0088, 32'h0000_0007);
    do_write(32'h0000_0084, 32'h0000_00FF);
    check("rd_out1", rdata, 32'hFF);
    adv(17);
    check("ord_hex3", {25'd0, hex3}, 32'h12);
    check("ord_hex2", {25'd0, hex2}, 32'h12);
    check("ord_hex4_early", {25'd0, hex4}, 32'h40);
    adv(9);
    check("ord_hex4_w29", {25'd0, hex4}, 32'h40);
    adv(1);
    check("ord_hex5", {25'd0, hex5}, {25'd0, TENS_ZERO});
    check("ord_hex4", {25'd0, hex4}, 32'h78);
    check("ord_hex1_kept", {25'd0, hex1}, 32'h19);

    // OUT0 = 5, then OUT0 = 9 during its own conversion -> reconversion
    do_write(32'h0000_0080, 32'h0000_0005);
    adv(3);
    do_write(32'h0000_0080, 32'h0000_0009);
    adv(5);
    check("rc_hex0_w9", {25'd0, hex0}, 32'h24);
    adv(1);
    check("rc_hex0_w10", {25'd0, hex0}, 32'h12);
    check("rc_hex1_w10", {25'd0, hex1}, {25'd0, TENS_ZERO});
    adv(9);
    check("rc_hex0_w19", {25'd0, hex0}, 32'h12);
    check("rc_busy_w19", {31'd0, busy}, 32'd1);
    adv(1);
    check("rc_hex0_w20", {25'd0, hex0}, 32'h10);

    // Same-edge write/select on OUT0 and two writes while pending: last wins, one conversion
    do_write(32'h0000_0088, 32'h0000_0001);
    do_write(32'h0000_0080, 32'h0000_0030);
    do_write(32'h0000_0080, 32'h0000_004D);
    adv(18);
    check("lw_hex4", {25'd0, hex4}, 32'h79);
    check("lw_hex1", {25'd0, hex1}, 32'h78);
    check("lw_hex0", {25'd0, hex0}, 32'h78);
    check("lw_busy_w20", {31'd0, busy}, 32'd0);
    adv(1);
    check("lw_busy_w21", {31'd0, busy}, 32'd0);

    // Unmapped write, IN-port write, upper address bits ignored
    we    = 1'b1;
    addr  = 32'h0000_0090;
    wdata = 32'h0000_0055;
    #1;
    check("um_iosel", {31'd0, io_sel}, 32'd0);
    check("um_rdata", rdata, 32'd0);
    adv(1);
    addr = 32'h0000_00C0;
    adv(1);
    we = 1'b0;
    adv(2);
    check("um_busy", {31'd0, busy}, 32'd0);
    check("um_hex0", {25'd0, hex0}, 32'h78);
    check("um_in0", rdata, 32'd0);
    addr = 32'hFFFF_FF80;
    #1;
    check("hi_iosel", {31'd0, io_sel}, 32'd1);
    check("hi_rdata", rdata, 32'h4D);

    // Reset during SHIFT of OUT1 = 0x63 aborts the conversion
    do_write(32'h0000_0084, 32'h0000_0063);
    adv(3);
    check("ab_busy_pre", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    adv(1);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_hex3", {25'd0, hex3}, {25'd0, TENS_RST});
    check("ab_hex2", {25'd0, hex2}, 32'h40);
    resetn = 1'b1;
    adv(12);
    check("ab_hex3_late", {25'd0, hex3}, {25'd0, TENS_RST});
    check("ab_hex2_late", {25'd0, hex2}, 32'h40);
    check("ab_busy_late", {31'd0, busy}, 32'd0);

    // Bouncing switches never reach the debounced register
    addr = 32'h0000_00C0;
    for (int i = 0; i < 12; i++) begin
      sw = (i % 2 == 0) ? 10'h3A5 : 10'h000;
      adv(5);
      check("bounce_in0", rdata, 32'd0);
    end
    sw = 10'd0;
    do_reset();

    // Stable switches: visible after exactly 2 + 16 edges
    sw = 10'h3A5;
    adv(17);
    check("deb_in0_e17", rdata, 32'd0);
    adv(1);
    check("deb_iosel", {31'd0, io_sel}, 32'd1);
    check("deb_in0", rdata, 32'h05);
    addr = 32'h0000_00C4;
    #1;
    check("deb_in1", rdata, 32'h1D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
